sp_inst_feeder: RTL and testbench
=================================

# sp_inst_feeder

Synthesizable, parametrised instruction feeder and retirement checker that drives the simple processor's `in_valid`/`inst` port from a program ROM and consumes its `out_valid`/`inst_addr` responses. It replaces the fixed behavioural pattern with one block that supports both a branch-following single-issue mode and a pipelined streaming mode with up to `MAX_INFLIGHT` outstanding instructions. It sits between the program ROM and the processor in the top-level bench and in FPGA self-test builds. It reports `done`, `pass`, an error count and a cycle count.

## Interface
- `MODE`, 0: 0 = follow (single issue, next PC taken from `inst_addr`); 1 = stream (sequential issue, in-order retire check).
- `MAX_INFLIGHT`, 4: maximum outstanding instructions in stream mode (1..16). Forced to 1 in follow mode.
- `ROM_DEPTH`, 256: program ROM words (power of two).
- `TIMEOUT`, 1024: watchdog cycles with no issue and no retire while instructions are outstanding.
- `clk` in 1: clock.
- `rst_n` in 1: reset. One clock; reset is synchronous and active-low.
- `start` in 1: one-cycle pulse that begins a run from PC 0. Ignored unless the state is IDLE or DONE.
- `prog_len` in $clog2(ROM_DEPTH)+1: program length in words. Sampled on `start`.
- `rom_addr` out $clog2(ROM_DEPTH): word address, equal to `pc[..:2]`. Combinational from the `pc` register.
- `rom_data` in 32: ROM word. Combinational read, valid in the same cycle.
- `in_valid` out 1: registered one-cycle strobe for each instruction issued to the processor.
- `inst` out 32: registered instruction. Valid while `in_valid` is high; holds its value otherwise.
- `out_valid` in 1: processor completion strobe.
- `inst_addr` in 32: processor PC. Follow mode: next PC. Stream mode: PC of the retiring instruction.
- `done` out 1: run finished. Sticky until the next `start`.
- `pass` out 1: `done` AND `err_cnt` == 0.
- `err_cnt` out 16: error count, saturating at 0xFFFF.
- `cycle_cnt` out 32: cycles from `start` to `done`.

## Operation
- States:
  - IDLE: `start` -> ISSUE, with `pc`=0, counters cleared and the FIFO emptied.
  - ISSUE: issues one instruction when `inflight` < `MAX_INFLIGHT` and `pc[..:2]` < `prog_len`.
    - Follow mode: after an issue -> WAIT.
    - Stream mode: stays in ISSUE until `pc[..:2]` == `prog_len`, then -> DRAIN.
  - WAIT (follow mode): on `out_valid`:
    - if `inst_addr[1:0]` != 0 or `inst_addr[..:2]` >= `prog_len` -> DONE. A misaligned address also increments `err_cnt`.
    - otherwise `pc` <= `inst_addr`, -> ISSUE.
  - DRAIN (stream mode): `inflight` == 0 -> DONE.
  - DONE: `done`=1. `start` -> ISSUE.
- Issue action: on the next edge, `in_valid`<=1, `inst`<=`rom_data`, push `pc` into the PC FIFO, `pc`<=`pc`+4, `inflight`+1.
- Retire action (stream mode): on `out_valid`, pop the FIFO head. If head != `inst_addr`, increment `err_cnt`; the instruction still retires. `inflight`-1.
- Simultaneous issue and retire in one cycle: `inflight` is unchanged, and FIFO push and pop both occur.
- `out_valid` while `inflight`==0: increment `err_cnt`, no pop, no state change. In IDLE it is ignored.
- `start` during ISSUE, WAIT or DRAIN: ignored.
- `rst_n` low mid-run: on the next edge, return to IDLE, empty the FIFO, and clear all counters and outputs.
- Width rules:
  - `pc` is 32 bits and wraps modulo 2^32.
  - `cycle_cnt` wraps.
  - `err_cnt` saturates.

## Timing
- Reset values: `in_valid`=0, `inst`=0, `done`=0, `pass`=0, `err_cnt`=0, `cycle_cnt`=0, `rom_addr`=0, state=IDLE.
- `start` at edge N -> first `in_valid` at edge N+2. N+1 is the first ISSUE cycle; `in_valid` rises after it.
- Stream mode, no stalls: one issue per cycle until `inflight` reaches `MAX_INFLIGHT`.
- Follow mode: the next `in_valid` comes 2 cycles after the `out_valid` that supplies the next PC.
- `done` rises on the edge after the terminating condition is met. `pass` is valid in the same cycle.
- `cycle_cnt` counts every cycle in ISSUE, WAIT and DRAIN.

## Configuration
- `SP_FEED_WATCHDOG_EN` defined:
  - A counter clears on each issue or retire and increments while `inflight` > 0.
  - When it reaches `TIMEOUT`: `err_cnt`+1, FIFO flushed, -> DONE.
- Not defined: no watchdog logic, and the `TIMEOUT` parameter is unused. A stalled processor leaves the block in WAIT or DRAIN indefinitely.

## Structure
- Package `sp_feed_pkg`:
  - state enum (IDLE, ISSUE, WAIT, DRAIN, DONE)
  - `MODE_FOLLOW`/`MODE_STREAM` constants
  - `ERR_CNT_W`=16
- Sub-module `sp_feed_fifo`:
  - synchronous PC FIFO, depth `MAX_INFLIGHT`, width 32
  - push/pop in the same cycle is allowed, including when full (the pop frees the slot)
  - full/empty flags
  - cleared by `rst_n` or the flush signal

## Test plan
- Follow mode, `prog_len`=4, processor returns PC 4, 8, 12, 16 -> 4 issues with `inst`=rom[0..3]; `done`=1, `pass`=1, `err_cnt`=0.
- Follow mode, branch: the response to the instruction at 0 is `inst_addr`=12 -> next `in_valid` carries rom[3]; the run ends after the following response.
- Stream mode, `MAX_INFLIGHT`=4, `prog_len`=8, processor retires 3 cycles after issue -> `in_valid` stays high for 4 cycles, then issue and retire overlap; 8 retires, `pass`=1.
- Stream mode, processor reports 0x14 where 0x10 is expected -> `err_cnt`=1, run completes, `pass`=0.
- Spurious `out_valid` while `inflight`=0 in ISSUE, and `start` asserted mid-run -> `err_cnt`=1; the second `start` has no effect.
- With the macro defined and `TIMEOUT`=16, the processor never answers -> `done` 17 cycles after the first issue, `err_cnt`=1. Reset asserted mid-run -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/sp_feed_pkg.sv
// Shared types and constants for the instruction feeder.
//   feed_state_t : controller states
//   MODE_FOLLOW  : single issue, next PC taken from the processor
//   MODE_STREAM  : sequential issue with in-order retire checking
//   ERR_CNT_W    : width of the saturating error counter
package sp_feed_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DRAIN,
        ST_DONE
    } feed_state_t;

    localparam int MODE_FOLLOW = 0;
    localparam int MODE_STREAM = 1;
    localparam int ERR_CNT_W   = 16;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/sp_feed_fifo.sv
// PC FIFO holding the addresses of outstanding instructions.
//   clk, rst_n : clock, synchronous active-low reset
//   flush      : empties the FIFO on the next edge
//   push/push_data : write one 32-bit PC
//   pop        : discard the head entry
//   head       : current head entry
//   full/empty : occupancy flags
// Push and pop in the same cycle are allowed, including when full.
module sp_feed_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] head,
    output logic        full,
    output logic        empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/sp_inst_feeder.sv
// Instruction feeder and retirement checker for the simple processor.
// Reads a program ROM, issues instructions on in_valid/inst and checks the
// processor's out_valid/inst_addr responses.
//   clk, rst_n          : clock, synchronous active-low reset
//   start, prog_len     : begin a run from PC 0 with prog_len words
//   rom_addr, rom_data  : combinational program ROM port
//   in_valid, inst      : registered issue strobe and instruction
//   out_valid, inst_addr: processor completion strobe and PC
//   done, pass          : run finished / finished with no errors
//   err_cnt, cycle_cnt  : saturating error count, active cycle count
// Optional feature: SP_FEED_WATCHDOG_EN adds a no-progress watchdog that
// ends the run after TIMEOUT stalled cycles.
//
// state | meaning
// IDLE  | waiting for the first start
// ISSUE | issuing while below the outstanding limit and inside the program
// WAIT  | follow mode: waiting for the next PC from the processor
// DRAIN | stream mode: all issued, waiting for outstanding retires
// DONE  | run finished, outputs held until the next start
module sp_inst_feeder
    import sp_feed_pkg::*;
#(
    parameter int MODE         = MODE_FOLLOW,
    parameter int MAX_INFLIGHT = 4,
    parameter int ROM_DEPTH    = 256,
    parameter int TIMEOUT      = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [$clog2(ROM_DEPTH):0]    prog_len,
    output logic [$clog2(ROM_DEPTH)-1:0]  rom_addr,
    input  logic [31:0]                   rom_data,
    output logic                          in_valid,
    output logic [31:0]                   inst,
    input  logic                          out_valid,
    input  logic [31:0]                   inst_addr,
    output logic                          done,
    output logic                          pass,
    output logic [ERR_CNT_W-1:0]          err_cnt,
    output logic [31:0]                   cycle_cnt
);
    localparam int AW  = $clog2(ROM_DEPTH);
    localparam int LIM = (MODE == MODE_FOLLOW) ? 1 : MAX_INFLIGHT;

    if (MAX_INFLIGHT < 1 || MAX_INFLIGHT > 16 || TIMEOUT < 1 ||
        (ROM_DEPTH & (ROM_DEPTH - 1)) != 0) begin : g_param_check
        $error("sp_inst_feeder: illegal parameter value");
    end

    feed_state_t state, state_nxt;
    logic [31:0] pc;
    logic [AW:0] len_q;
    logic        fifo_full, fifo_empty;
    logic [31:0] fifo_head;
    logic        active, start_ok, in_range, next_ok;
    logic        issue, retire, spurious, err_event, flush, wd_fire;

    assign rom_addr = pc[AW+1:2];
    assign active   = (state == ST_ISSUE) || (state == ST_WAIT) || (state == ST_DRAIN);
    assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign in_range = ({2'b00, pc[31:2]} < 32'(len_q));
    assign next_ok  = (inst_addr[1:0] == 2'b00) && ({2'b00, inst_addr[31:2]} < 32'(len_q));

    assign issue    = (state == ST_ISSUE) && !fifo_full && in_range;
    // The FIFO occupancy is the outstanding-instruction count.
    assign retire   = out_valid && (state != ST_IDLE) && !fifo_empty;
    assign spurious = out_valid && (state != ST_IDLE) && fifo_empty;
    assign flush    = start_ok || wd_fire;

    // At most one error source can be true in a cycle: spurious needs an
    // empty FIFO, retire and the watchdog need a non-empty one and the
    // watchdog is pre-empted by any retire.
    assign err_event = spurious || wd_fire
                     || ((MODE == MODE_STREAM) && retire && (fifo_head != inst_addr))
                     || ((MODE == MODE_FOLLOW) && (state == ST_WAIT) && out_valid
                         && (inst_addr[1:0] != 2'b00));

    assign pass = done && (err_cnt == '0);

`ifdef SP_FEED_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wd_cnt;

    // Down-counter reloaded on any progress or when nothing is outstanding;
    // it reaches zero TIMEOUT stalled cycles after the last progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (start_ok || issue || retire || fifo_empty) begin
            wd_cnt <= WW'(TIMEOUT);
        end else if (wd_cnt != '0) begin
            wd_cnt <= wd_cnt - WW'(1);
        end
    end

    assign wd_fire = active && !fifo_empty && !issue && !retire && (wd_cnt == '0);
`else
    assign wd_fire = 1'b0;
`endif

    sp_feed_fifo #(
        .DEPTH (LIM)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (issue),
        .push_data (pc),
        .pop       (retire),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                if (MODE == MODE_FOLLOW) begin
                    if (issue)          state_nxt = ST_WAIT;
                    else if (!in_range) state_nxt = ST_DONE;
                end else if (!in_range) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_WAIT:  if (out_valid) state_nxt = next_ok ? ST_ISSUE : ST_DONE;
            ST_DRAIN: if (fifo_empty) state_nxt = ST_DONE;
            ST_DONE:  if (start) state_nxt = ST_ISSUE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (wd_fire) state_nxt = ST_DONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pc        <= '0;
            len_q     <= '0;
            in_valid  <= 1'b0;
            inst      <= '0;
            done      <= 1'b0;
            err_cnt   <= '0;
            cycle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            in_valid <= issue;
            if (issue) begin
                inst <= rom_data;
                pc   <= pc + 32'd4;
            end
            if (start_ok) begin
                pc        <= '0;
                len_q     <= prog_len;
                done      <= 1'b0;
                err_cnt   <= '0;
                cycle_cnt <= '0;
            end else begin
                if (active) cycle_cnt <= cycle_cnt + 32'd1;
                if ((state == ST_WAIT) && out_valid && next_ok) pc <= inst_addr;
                if (err_event) err_cnt <= sat_inc(err_cnt);
                if (state_nxt == ST_DONE) done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sp_inst_feeder.sv
module tb_sp_inst_feeder;
    localparam int ROM_DEPTH = 256;
    localparam int AW        = 8;
    localparam int TIMEOUT   = 16;
    localparam int MAXI      = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic [31:0] rom [ROM_DEPTH];

    logic          f_start, f_in_valid, f_out_valid, f_done, f_pass;
    logic [AW:0]   f_len;
    logic [AW-1:0] f_rom_addr;
    logic [31:0]   f_rom_data, f_inst, f_inst_addr, f_cyc;
    logic [15:0]   f_err;

    logic          s_start, s_in_valid, s_out_valid, s_done, s_pass;
    logic [AW:0]   s_len;
    logic [AW-1:0] s_rom_addr;
    logic [31:0]   s_rom_data, s_inst, s_inst_addr, s_cyc;
    logic [15:0]   s_err;

    assign f_rom_data = rom[f_rom_addr];
    assign s_rom_data = rom[s_rom_addr];

    int checks   = 0;
    int failures = 0;
    logic [31:0] fresp[$];

    sp_inst_feeder #(.MODE(0), .MAX_INFLIGHT(MAXI), .ROM_DEPTH(ROM_DEPTH), .TIMEOUT(TIMEOUT)) u_follow (
        .clk(clk), .rst_n(rst_n), .start(f_start), .prog_len(f_len),
        .rom_addr(f_rom_addr), .rom_data(f_rom_data), .in_valid(f_in_valid), .inst(f_inst),
        .out_valid(f_out_valid), .inst_addr(f_inst_addr), .done(f_done), .pass(f_pass),
        .err_cnt(f_err), .cycle_cnt(f_cyc));

    sp_inst_feeder #(.MODE(1), .MAX_INFLIGHT(MAXI), .ROM_DEPTH(ROM_DEPTH), .TIMEOUT(TIMEOUT)) u_stream (
        .clk(clk), .rst_n(rst_n), .start(s_start), .prog_len(s_len),
        .rom_addr(s_rom_addr), .rom_data(s_rom_data), .in_valid(s_in_valid), .inst(s_inst),
        .out_valid(s_out_valid), .inst_addr(s_inst_addr), .done(s_done), .pass(s_pass),
        .err_cnt(s_err), .cycle_cnt(s_cyc));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        f_start = 0; f_len = '0; f_out_valid = 0; f_inst_addr = '0;
        s_start = 0; s_len = '0; s_out_valid = 0; s_inst_addr = '0;
        repeat (2) tick();
        checks++;
        if ({f_in_valid, f_inst, f_done, f_pass, f_err, f_cyc, f_rom_addr} !== '0) begin
            failures++;
            $display("FAIL reset_follow: outputs=%h required 0",
                     {f_in_valid, f_inst, f_done, f_pass, f_err, f_cyc, f_rom_addr});
        end
        checks++;
        if ({s_in_valid, s_inst, s_done, s_pass, s_err, s_cyc, s_rom_addr} !== '0) begin
            failures++;
            $display("FAIL reset_stream: outputs=%h required 0",
                     {s_in_valid, s_inst, s_done, s_pass, s_err, s_cyc, s_rom_addr});
        end
        rst_n = 1'b1;
        tick();
        s_out_valid = 1; s_inst_addr = 32'h10;
        tick();
        s_out_valid = 0;
        tick();
        checks++;
        if (s_err !== 16'd0 || s_done !== 1'b0) begin
            failures++;
            $display("FAIL idle_out_valid: err=%0d done=%b required err=0 done=0", s_err, s_done);
        end
    endtask

    // Follow-mode run; the processor's successive next-PC answers are in fresp.
    task automatic test_follow(input int len, input string name);
        logic [31:0] pc, a;
        int k, edges, exp_err, lat;
        bit fin, ok;
        pc = 0; k = 0; edges = 0; exp_err = 0; fin = 0; ok = 1;
        f_len = (AW+1)'(len);
        f_start = 1;
        tick();
        f_start = 0;
        while (!fin && ok && k < fresp.size()) begin
            tick(); edges++;
            checks++;
            if (f_in_valid !== 1'b1) begin
                failures++; ok = 0;
                $display("FAIL %s issue_timing: in_valid=%b required 1 (pc=%h)", name, f_in_valid, pc);
            end else begin
                checks++;
                if (f_inst !== rom[pc[AW+1:2]]) begin
                    failures++;
                    $display("FAIL %s inst: got=%h required=%h (pc=%h)", name, f_inst, rom[pc[AW+1:2]], pc);
                end
                lat = $urandom_range(0, 2);
                repeat (lat) begin tick(); edges++; end
                a = fresp[k]; k++;
                f_out_valid = 1; f_inst_addr = a;
                tick(); edges++;
                f_out_valid = 0;
                if (a[1:0] != 2'b00 || (a >> 2) >= len) begin
                    fin = 1;
                    if (a[1:0] != 2'b00) exp_err++;
                    checks++;
                    if (f_done !== 1'b1) begin
                        failures++;
                        $display("FAIL %s done_edge: done=%b required 1", name, f_done);
                    end
                end else begin
                    pc = a;
                    checks++;
                    if (f_in_valid !== 1'b0 || f_done !== 1'b0) begin
                        failures++;
                        $display("FAIL %s wait_edge: in_valid=%b done=%b required 0 0", name, f_in_valid, f_done);
                    end
                end
            end
        end
        checks++;
        if (f_done !== 1'b1 || f_err !== 16'(exp_err) || f_pass !== (exp_err == 0)) begin
            failures++;
            $display("FAIL %s result: done=%b err=%0d pass=%b required 1 %0d %b",
                     name, f_done, f_err, f_pass, exp_err, exp_err == 0);
        end
        checks++;
        if (f_cyc !== 32'(edges)) begin
            failures++;
            $display("FAIL %s cycle_cnt: got=%0d required=%0d", name, f_cyc, edges);
        end
    endtask

    task automatic test_follow_random();
        int len, a;
        len = $urandom_range(4, 12);
        fresp.delete();
        repeat (6) begin
            a = $urandom_range(0, len - 1);
            fresp.push_back(32'(a * 4));
        end
        if ($urandom_range(0, 1) == 1) fresp.push_back(32'(len * 4));
        else fresp.push_back(32'($urandom_range(0, len - 1) * 4 + 2));
        test_follow(len, "follow_random");
    endtask

    // Stream-mode run with a responder retiring in order after a random latency.
    task automatic test_stream(input int len, input int lat_min, input int lat_max,
                               input int err_idx, input bit spurious, input bit midstart,
                               input string name);
        int due[$];
        int iss_cyc[$];
        int cyc, n_iss, n_ret, exp_err;
        exp_err = ((err_idx >= 0 && err_idx < len) ? 1 : 0) + (spurious ? 1 : 0);
        cyc = 0; n_iss = 0; n_ret = 0;
        s_len = (AW+1)'(len);
        s_start = 1;
        tick();
        s_start = 0;
        if (spurious) begin s_out_valid = 1; s_inst_addr = 32'h0; end
        while (cyc < 2000) begin
            tick(); cyc++;
            s_start = (midstart && cyc == 3);
            s_out_valid = 0;
            if (s_in_valid === 1'b1) begin
                checks++;
                if (s_inst !== rom[n_iss % ROM_DEPTH]) begin
                    failures++;
                    $display("FAIL %s inst[%0d]: got=%h required=%h", name, n_iss, s_inst, rom[n_iss % ROM_DEPTH]);
                end
                iss_cyc.push_back(cyc);
                due.push_back(cyc + $urandom_range(lat_min, lat_max));
                n_iss++;
            end
            if (n_iss - n_ret > MAXI) begin
                checks++; failures++;
                $display("FAIL %s inflight: got=%0d required<=%0d", name, n_iss - n_ret, MAXI);
            end
            if (s_done === 1'b1) break;
            if (due.size() > 0 && due[0] <= cyc) begin
                void'(due.pop_front());
                s_out_valid = 1;
                s_inst_addr = 32'(4 * n_ret) + ((n_ret == err_idx) ? 32'd4 : 32'd0);
                n_ret++;
            end
        end
        s_out_valid = 0; s_start = 0;
        checks++;
        if (s_done !== 1'b1 || n_iss != len || n_ret != len) begin
            failures++;
            $display("FAIL %s completion: done=%b issued=%0d retired=%0d required 1 %0d %0d",
                     name, s_done, n_iss, n_ret, len, len);
        end
        checks++;
        if (s_err !== 16'(exp_err) || s_pass !== (exp_err == 0)) begin
            failures++;
            $display("FAIL %s errors: err=%0d pass=%b required %0d %b", name, s_err, s_pass, exp_err, exp_err == 0);
        end
        checks++;
        if (s_cyc !== 32'(cyc)) begin
            failures++;
            $display("FAIL %s cycle_cnt: got=%0d required=%0d", name, s_cyc, cyc);
        end
        if (lat_min >= 3 && len >= MAXI && iss_cyc.size() > MAXI) begin
            checks++;
            if (iss_cyc[MAXI-1] - iss_cyc[0] != MAXI - 1 || iss_cyc[MAXI] - iss_cyc[MAXI-1] < 2) begin
                failures++;
                $display("FAIL %s burst: first=%0d last=%0d next=%0d required back-to-back %0d then a gap",
                         name, iss_cyc[0], iss_cyc[MAXI-1], iss_cyc[MAXI], MAXI);
            end
        end
    endtask

    task automatic test_watchdog();
        int n;
        f_len = 9'd4;
        f_start = 1;
        tick();
        f_start = 0;
        tick();
        checks++;
        if (f_in_valid !== 1'b1) begin
            failures++;
            $display("FAIL wd_first_issue: in_valid=%b required 1", f_in_valid);
        end
        n = 0;
        while (n < 40 && f_done !== 1'b1) begin tick(); n++; end
`ifdef SP_FEED_WATCHDOG_EN
        checks++;
        if (n != 17 || f_err !== 16'd1 || f_pass !== 1'b0) begin
            failures++;
            $display("FAIL watchdog: done after %0d err=%0d pass=%b required 17 1 0", n, f_err, f_pass);
        end
`else
        checks++;
        if (f_done !== 1'b0 || f_err !== 16'd0) begin
            failures++;
            $display("FAIL no_watchdog: done=%b err=%0d required 0 0", f_done, f_err);
        end
`endif
    endtask

    task automatic test_reset_midrun();
        s_len = 9'd8;
        s_start = 1;
        tick();
        s_start = 0;
        repeat (3) tick();
        rst_n = 0;
        tick();
        checks++;
        if ({s_in_valid, s_inst, s_done, s_pass, s_err, s_cyc, s_rom_addr} !== '0) begin
            failures++;
            $display("FAIL midrun_reset_stream: outputs=%h required 0",
                     {s_in_valid, s_inst, s_done, s_pass, s_err, s_cyc, s_rom_addr});
        end
        checks++;
        if ({f_in_valid, f_inst, f_done, f_pass, f_err, f_cyc, f_rom_addr} !== '0) begin
            failures++;
            $display("FAIL midrun_reset_follow: outputs=%h required 0",
                     {f_in_valid, f_inst, f_done, f_pass, f_err, f_cyc, f_rom_addr});
        end
        rst_n = 1;
        tick();
        test_stream(6, 0, 4, -1, 0, 0, "after_reset");
    endtask

    initial begin
        for (int i = 0; i < ROM_DEPTH; i++) rom[i] = $urandom;
        test_reset();

        fresp.delete();
        fresp.push_back(32'd4); fresp.push_back(32'd8); fresp.push_back(32'd12); fresp.push_back(32'd16);
        test_follow(4, "follow_seq");

        fresp.delete();
        fresp.push_back(32'd12); fresp.push_back(32'd16);
        test_follow(4, "follow_branch");

        fresp.delete();
        fresp.push_back(32'd4); fresp.push_back(32'd6);
        test_follow(8, "follow_misaligned");

        for (int i = 0; i < 3; i++) test_follow_random();

        test_stream(8, 3, 3, -1, 0, 0, "stream_lat3");
        test_stream(8, 1, 4, 4, 0, 0, "stream_bad_addr");
        test_stream(8, 0, 3, -1, 1, 1, "stream_spurious_start");
        for (int i = 0; i < 3; i++)
            test_stream($urandom_range(1, 20), 0, 6, $urandom_range(0, 1) ? -1 : $urandom_range(0, 19), 0, 0,
                        "stream_random");

        test_watchdog();
        test_reset_midrun();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
